// File: rtl/conv_frame_writer.sv
// Captures one frame of filtered RGB pixels per start request and writes it to a frame buffer with border blanking.
// Latency: each accepted pixel appears on the write port one cycle later, with registered address and data.
// Backpressure: none; the stream is valid-qualified only, and pixels outside CAPTURE are dropped.
module conv_frame_writer #(
    parameter int LINE_WIDTH   = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int PIXEL_DEPTH  = 8,
    parameter int ADDR_WIDTH   = 19,
    parameter int BORDER       = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     valid_i,
    input  logic [PIXEL_DEPTH-1:0]   input_R,
    input  logic [PIXEL_DEPTH-1:0]   input_G,
    input  logic [PIXEL_DEPTH-1:0]   input_B,
    output logic                     wr_en,
    output logic [ADDR_WIDTH-1:0]    wr_addr,
    output logic [3*PIXEL_DEPTH-1:0] wr_data,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int XW = (LINE_WIDTH   > 1) ? $clog2(LINE_WIDTH)   : 1;
    localparam int YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  accept;
    logic                  clear_cnt;
    logic                  last_pix;
    logic                  blank;
    logic [XW-1:0]         x_cnt;
    logic [YW-1:0]         y_cnt;
    logic [ADDR_WIDTH-1:0] addr_cnt;

    assign last_pix = (x_cnt == XW'(LINE_WIDTH - 1)) && (y_cnt == YW'(FRAME_HEIGHT - 1));
    assign busy     = (state == S_CAPTURE);

    // Border blanking covers the edge pixels where the sliding window was incomplete.
    generate
        if (BORDER == 0) begin : g_no_blank
            assign blank = 1'b0;
        end else begin : g_blank
            assign blank = (x_cnt <  XW'(BORDER))
                        || (x_cnt >= XW'(LINE_WIDTH - BORDER))
                        || (y_cnt <  YW'(BORDER))
                        || (y_cnt >= YW'(FRAME_HEIGHT - BORDER));
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; pixels are only accepted while capturing, and a new frame clears the counters.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        clear_cnt = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_CAPTURE;
                    clear_cnt = 1'b1;
                end
            end
            S_CAPTURE: begin
                accept = valid_i;
                if (valid_i && last_pix) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_nxt = S_CAPTURE;
                    clear_cnt = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Column/row and linear address counters; the address is a running count so no multiplier is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt    <= '0;
            y_cnt    <= '0;
            addr_cnt <= '0;
        end else if (clear_cnt) begin
            x_cnt    <= '0;
            y_cnt    <= '0;
            addr_cnt <= '0;
        end else if (accept) begin
            addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
            if (x_cnt == XW'(LINE_WIDTH - 1)) begin
                x_cnt <= '0;
                y_cnt <= last_pix ? '0 : y_cnt + YW'(1);
            end else begin
                x_cnt <= x_cnt + XW'(1);
            end
        end
    end

    // Registered write port; address and data hold their last values between accepted pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
        end else begin
            wr_en      <= accept;
            frame_done <= accept && last_pix;
            if (accept) begin
                wr_addr <= addr_cnt;
                wr_data <= blank ? '0 : {input_R, input_G, input_B};
            end
        end
    end

endmodule
